cordic_table_loader: RTL and testbench
======================================

Name: cordic_table_loader

Overview:
- Upstream loader for the CORDIC/ROM amplitude table inside the DDFS core.
- Accepts a 16-bit word stream over a valid/ready handshake and packs three words into each 48-bit table entry.
- Drives the core's table write port (wen, index_wri, D) for all entries, then asserts cen so the phase-to-amplitude path may run.
- Sits between the host/config interface and the DDFS core.

Parameters:
- DEPTH, 64, number of table entries; index width is fixed at 6 bits, so DEPTH must be ≤ 64.
- WORD_W, 16, width of one input stream word.
- WPE, 3, words per entry; D width = WORD_W*WPE = 48.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins or restarts a table load.
- s_valid  input  1  stream word valid.
- s_data  input  16  stream word.
- s_ready  output  1  loader accepts a word this cycle.
- wen  output  1  table write strobe, one cycle per entry.
- index_wri  output  6  table write address.
- D  output  48  table write data.
- cen  output  1  core enable; high only while a complete, valid table is loaded.
- busy  output  1  high while a load is in progress.
- done  output  1  one-cycle pulse when a load completes successfully.
- err  output  1  sticky checksum error (feature only; otherwise constant 0).

Behaviour:
- Reset (asynchronous): state IDLE; all outputs 0; word counter, entry index and pack register cleared.
- FSM states: IDLE, COLLECT, WRITE, CHECK (feature only), READY.
- IDLE: s_ready = 0. On start → COLLECT, index 0, word count 0, cen = 0, err = 0.
- COLLECT:
  - s_ready = 1, busy = 1.
  - Each handshake (s_valid & s_ready) shifts s_data into the pack register, MSB-first: the first word of an entry lands in D[47:32], the second in D[31:16], the third in D[15:0].
  - On the WPE-th handshake → WRITE.
- WRITE:
  - Exactly one cycle; s_ready = 0; wen = 1; D and index_wri stable.
  - If index = DEPTH-1 → CHECK (feature) or READY; otherwise index++ and → COLLECT.
- Latency and throughput:
  - wen rises the cycle after the third handshake.
  - Minimum 4 cycles per entry; 256 cycles for a full table with s_valid held high.
- READY: cen = 1, busy = 0. done pulses for one cycle on entry to READY.
- Outside WRITE: wen = 0. D and index_wri hold their last values.
- start in any non-IDLE state (including mid-load and READY):
  - Drop cen the same cycle.
  - Discard any partial entry; index and word count go to 0; err clears; → COLLECT.
  - Entries already written are not cleared; they are overwritten on reload.
- start coinciding with a handshake: start wins and the word is dropped. s_ready is 0 in the cycle start is sampled, so no handshake can actually coincide.
- s_valid low in COLLECT: wait indefinitely; no timeout.
- reset mid-load: → IDLE immediately; cen = 0; the table contents are undefined until the next full load.

Optional Feature:
- Macro: CORDIC_TABLE_CHECKSUM_EN.
- With the macro:
  - A 16-bit running sum (mod 2^16) is kept over all DEPTH*WPE accepted words.
  - After the last WRITE, the FSM enters CHECK with s_ready = 1 and accepts one more word.
  - Match → READY with a done pulse.
  - Mismatch → IDLE with err = 1 (sticky until start or reset), cen = 0, no done.
- Without the macro: no CHECK state, no sum register, err tied to 0.

Decomposition:
- Shared package:
  - State enum.
  - DEPTH/WPE/WORD_W defaults.
  - IDX_W = 6 and DATA_W = 48 constants shared with the DDFS core.
- One natural sub-module: cordic_word_packer, a WPE-word shift register with word counter and "entry full" flag. The FSM and address counter stay in the top module.

Test Plan:
- Full load, s_valid always 1, words 0x0000..0x00BF:
  - Entry 0 D = 0x000000010002 at index 0.
  - Entry 63 D = 0x00BD00BE00BF.
  - 64 wen pulses total; cen = 1 and done pulses at cycle 257 after start.
- Random s_valid gaps (~50% duty):
  - Same 64 entries written in order; no extra or missing wen.
  - s_ready = 0 during every WRITE cycle.
- start asserted after 100 words:
  - cen stays 0; index restarts at 0.
  - The next 192 words load cleanly, the first of them landing in D[47:32] of entry 0.
- reset asserted mid-WRITE: wen, cen, busy and s_ready drop asynchronously to 0; the FSM stays idle until start.
- start while in READY: cen falls the same cycle; a full reload completes with cen = 1 again.
- Checksum (CORDIC_TABLE_CHECKSUM_EN defined), words all 0x0001:
  - Sum word 0x00C0 → done pulses, cen = 1.
  - Sum word 0x00C1 → err = 1, cen = 0, no done.

Source files
------------

// File: rtl/cordic_table_loader_pkg.sv
// Shared types and constants for the DDFS amplitude-table loader and its packer.
// IDX_W and DATA_W are shared with the DDFS core's table write port. Optional checksum: CORDIC_TABLE_CHECKSUM_EN.
package cordic_table_loader_pkg;

   localparam int DEPTH_DEF  = 64;
   localparam int WORD_W_DEF = 16;
   localparam int WPE_DEF    = 3;
   localparam int IDX_W      = 6;
   localparam int DATA_W     = WORD_W_DEF * WPE_DEF;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_WRITE   = 3'd2,
      ST_READY   = 3'd3
`ifdef CORDIC_TABLE_CHECKSUM_EN
      , ST_CHECK = 3'd4
`endif
   } state_t;

   function automatic logic [IDX_W-1:0] last_index(input int depth);
      return IDX_W'(depth - 1);
   endfunction

endpackage

// File: rtl/cordic_word_packer.sv
// Packs WPE stream words MSB-first into one table entry; entry_full flags the completing word combinationally.
// Completed entry is registered and held until the next entry completes; clr drops any partial entry.
module cordic_word_packer
   import cordic_table_loader_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF,
   parameter int WPE    = WPE_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    shift,
   input  logic [WORD_W-1:0]       din,
   output logic [WORD_W*WPE-1:0]   entry,
   output logic                    entry_full
);

   localparam int ACC_W = WORD_W * (WPE - 1);
   localparam int CNT_W = $clog2(WPE);

   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;

   assign entry_full = shift && (cnt == CNT_W'(WPE - 1));

   // acc only holds the leading WPE-1 words; the final word goes straight into entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc   <= '0;
         cnt   <= '0;
         entry <= '0;
      end else if (clr) begin
         acc <= '0;
         cnt <= '0;
      end else if (shift) begin
         if (entry_full) begin
            entry <= {acc, din};
            cnt   <= '0;
         end else begin
            acc <= (acc << WORD_W) | ACC_W'(din);
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/cordic_table_loader.sv
// Loads the DDFS amplitude table from a 16-bit word stream, one wen per 3-word entry, then raises cen.
// 4 cycles minimum per entry; s_ready low in WRITE and in the start cycle. Optional checksum: CORDIC_TABLE_CHECKSUM_EN.
module cordic_table_loader
   import cordic_table_loader_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEF,
   parameter int WORD_W = WORD_W_DEF,
   parameter int WPE    = WPE_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    s_valid,
   input  logic [WORD_W-1:0]       s_data,
   output logic                    s_ready,
   output logic                    wen,
   output logic [IDX_W-1:0]        index_wri,
   output logic [WORD_W*WPE-1:0]   D,
   output logic                    cen,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);

   state_t            state;
   state_t            state_nxt;
   logic [IDX_W-1:0]  idx;
   logic              hs;
   logic              pack_shift;
   logic              entry_full;
   logic              last_entry;
   logic              done_nxt;

`ifdef CORDIC_TABLE_CHECKSUM_EN
   logic [WORD_W-1:0] sum;
   logic              err_q;
`endif

   // start blocks the handshake so a restart never swallows a word
`ifdef CORDIC_TABLE_CHECKSUM_EN
   assign s_ready = !start && ((state == ST_COLLECT) || (state == ST_CHECK));
`else
   assign s_ready = !start && (state == ST_COLLECT);
`endif

   assign hs         = s_valid && s_ready;
   assign pack_shift = hs && (state == ST_COLLECT);
   assign last_entry = (idx == last_index(DEPTH));

   cordic_word_packer #(
      .WORD_W (WORD_W),
      .WPE    (WPE)
   ) u_packer (
      .clk        (clk),
      .rst        (reset),
      .clr        (start),
      .shift      (pack_shift),
      .din        (s_data),
      .entry      (D),
      .entry_full (entry_full)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      wen       = 1'b0;
      busy      = 1'b0;
      cen       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) state_nxt = ST_COLLECT;
         end
         ST_COLLECT: begin
            busy = 1'b1;
            if (start)           state_nxt = ST_COLLECT;
            else if (entry_full) state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            busy = 1'b1;
            wen  = 1'b1;
            if (start)           state_nxt = ST_COLLECT;
`ifdef CORDIC_TABLE_CHECKSUM_EN
            else if (last_entry) state_nxt = ST_CHECK;
`else
            else if (last_entry) state_nxt = ST_READY;
`endif
            else                 state_nxt = ST_COLLECT;
         end
`ifdef CORDIC_TABLE_CHECKSUM_EN
         ST_CHECK: begin
            busy = 1'b1;
            if (start)   state_nxt = ST_COLLECT;
            else if (hs) state_nxt = (s_data == sum) ? ST_READY : ST_IDLE;
         end
`endif
         ST_READY: begin
            cen = !start;
            if (start) state_nxt = ST_COLLECT;
         end
         default: state_nxt = ST_IDLE;
      endcase
      done_nxt = (state_nxt == ST_READY) && (state != ST_READY);
   end

   // index_wri latches the entry address as the entry completes so it holds through and after WRITE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx       <= '0;
         index_wri <= '0;
         done      <= 1'b0;
      end else begin
         done <= done_nxt;
         if (start) begin
            idx       <= '0;
            index_wri <= '0;
         end else begin
            if (entry_full)                          index_wri <= idx;
            if ((state == ST_WRITE) && !last_entry)  idx       <= idx + 1'b1;
         end
      end
   end

`ifdef CORDIC_TABLE_CHECKSUM_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sum   <= '0;
         err_q <= 1'b0;
      end else if (start) begin
         sum   <= '0;
         err_q <= 1'b0;
      end else begin
         if (pack_shift)                                    sum   <= sum + s_data;
         if ((state == ST_CHECK) && hs && (s_data != sum))  err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_table_loader.sv
// Randomized scoreboard bench for cordic_table_loader; expected table writes come from the word list itself.
module tb_cordic_table_loader;
   import cordic_table_loader_pkg::*;

`ifdef CORDIC_TABLE_CHECKSUM_EN
   localparam int DONE_CYCLE = 258;
`else
   localparam int DONE_CYCLE = 257;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        s_valid;
   logic [15:0] s_data;
   logic        s_ready;
   logic        wen;
   logic [5:0]  index_wri;
   logic [47:0] D;
   logic        cen;
   logic        busy;
   logic        done;
   logic        err;

   int checks  = 0;
   int errors  = 0;
   int cyc     = 0;
   int wen_cnt = 0;
   int done_cnt = 0;

   logic [53:0] exp_q[$];
   logic [15:0] words[$];

   cordic_table_loader dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_ready   (s_ready),
      .wen       (wen),
      .index_wri (index_wri),
      .D         (D),
      .cen       (cen),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Table n words: entry e is words 3e..3e+2, first word in the top 16 bits
   function automatic void load_expect(input int n);
      for (int e = 0; e < n / 3 && e < 64; e++)
         exp_q.push_back({6'(e), words[3*e], words[3*e+1], words[3*e+2]});
   endfunction

   // Monitor: every wen pops one expected write
   always @(negedge clk) begin
      if (!reset) begin
         if (done) done_cnt++;
         if (wen) begin
            wen_cnt++;
            chk("s_ready_low_in_write", 64'(s_ready), 64'(0));
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_wen: index=%0d D=0x%0h with no write expected", index_wri, D);
            end else begin
               logic [53:0] e;
               e = exp_q.pop_front();
               chk("table_write", 64'({index_wri, D}), 64'(e));
            end
         end
      end
   end

   task automatic send_word(input logic [15:0] w, input bit gaps);
      bit ok;
      ok = 1'b0;
      if (gaps && ($urandom_range(1, 0) == 1)) begin
         s_valid = 1'b0;
         @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data  = w;
      for (int t = 0; t < 50 && !ok; t++) begin
         @(negedge clk);
         if (s_ready) ok = 1'b1;
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: word 0x%0h not accepted, required within 50 cycles", w);
      end
   endtask

   // start is driven mid-cycle; cen and s_ready must already be low in that cycle
   task automatic pulse_start(output int s0);
      start = 1'b1;
      #1;
      chk("cen_low_on_start", 64'(cen), 64'(0));
      chk("s_ready_low_on_start", 64'(s_ready), 64'(0));
      @(posedge clk); #1;
      s0    = cyc;
      start = 1'b0;
   endtask

   task automatic full_load(input bit gaps, input bit rnd, input bit chk_cycle);
      int          s0;
      int          w0;
      int          d0;
      bit          got;
      logic [15:0] sum;
      sum = '0;
      got = 1'b0;
      w0  = wen_cnt;
      words.delete();
      for (int i = 0; i < 192; i++) words.push_back(rnd ? 16'($urandom) : 16'(i));
      load_expect(192);
      pulse_start(s0);
      d0 = done_cnt;
      for (int i = 0; i < 192; i++) begin
         send_word(words[i], gaps);
         sum = sum + words[i];
      end
`ifdef CORDIC_TABLE_CHECKSUM_EN
      send_word(sum, gaps);
`endif
      for (int t = 0; t < 20 && !got; t++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            if (chk_cycle) chk("done_cycle", 64'(cyc - s0 + 1), 64'(DONE_CYCLE));
         end
      end
      chk("done_seen", 64'(got), 64'(1));
      chk("cen_after_load", 64'(cen), 64'(1));
      chk("busy_after_load", 64'(busy), 64'(0));
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 64'(0));
      chk("done_pulse_count", 64'(done_cnt - d0), 64'(1));
      chk("wen_count", 64'(wen_cnt - w0), 64'(64));
      chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
      @(posedge clk); #1;
   endtask

`ifdef CORDIC_TABLE_CHECKSUM_EN
   task automatic cksum_load(input logic [15:0] ck);
      int          s0;
      int          d0;
      bit          good;
      logic [15:0] model_sum;
      model_sum = '0;
      words.delete();
      for (int i = 0; i < 192; i++) begin
         words.push_back(16'h0001);
         model_sum = model_sum + 16'h0001;
      end
      good = (ck == model_sum);
      load_expect(192);
      pulse_start(s0);
      d0 = done_cnt;
      for (int i = 0; i < 192; i++) send_word(words[i], 1'b0);
      send_word(ck, 1'b0);
      repeat (5) @(negedge clk);
      chk("cksum_done_count", 64'(done_cnt - d0), 64'(good ? 1 : 0));
      chk("cksum_cen", 64'(cen), 64'(good ? 1 : 0));
      chk("cksum_err", 64'(err), 64'(good ? 0 : 1));
      chk("cksum_busy", 64'(busy), 64'(0));
      @(posedge clk); #1;
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      reset   = 1'b1;
      start   = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      #2;
      chk("rst_s_ready", 64'(s_ready), 64'(0));
      chk("rst_wen", 64'(wen), 64'(0));
      chk("rst_cen", 64'(cen), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_err", 64'(err), 64'(0));
      chk("rst_index", 64'(index_wri), 64'(0));
      chk("rst_D", 64'(D), 64'(0));
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;

      // Ramp load with s_valid held high
      full_load(1'b0, 1'b0, 1'b1);

      // Restart from READY, random data and gaps
      chk("cen_before_restart", 64'(cen), 64'(1));
      full_load(1'b1, 1'b1, 1'b0);

      // Abort after 100 words, then a clean reload
      words.delete();
      for (int i = 0; i < 100; i++) words.push_back(16'($urandom));
      load_expect(100);
      pulse_start(s0);
      for (int i = 0; i < 100; i++) send_word(words[i], 1'b1);
      chk("busy_mid_load", 64'(busy), 64'(1));
      chk("cen_mid_load", 64'(cen), 64'(0));
      full_load(1'b1, 1'b1, 1'b0);

      // Reset during a WRITE cycle
      pulse_start(s0);
      for (int i = 0; i < 3; i++) send_word(16'($urandom), 1'b0);
      chk("wen_before_reset", 64'(wen), 64'(1));
      reset = 1'b1;
      #1;
      chk("async_rst_wen", 64'(wen), 64'(0));
      chk("async_rst_cen", 64'(cen), 64'(0));
      chk("async_rst_busy", 64'(busy), 64'(0));
      chk("async_rst_s_ready", 64'(s_ready), 64'(0));
      @(posedge clk); #1;
      reset   = 1'b0;
      s_valid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("idle_busy", 64'(busy), 64'(0));
         chk("idle_s_ready", 64'(s_ready), 64'(0));
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      full_load(1'b1, 1'b1, 1'b0);

`ifdef CORDIC_TABLE_CHECKSUM_EN
      cksum_load(16'h00C0);
      cksum_load(16'h00C1);
`endif

      repeat (3) @(posedge clk);
      chk("final_scoreboard_empty", 64'(exp_q.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
